// File: rtl/cam_pkg.sv
// Shared geometry, frame-buffer constants and capture FSM states for the
// camera capture path and the VGA display that reads the same frame buffer.
package cam_pkg;

   localparam int unsigned H_ACT      = 640;
   localparam int unsigned V_ACT      = 480;
   localparam int unsigned AW         = 19;
   localparam int unsigned FRAME_SIZE = H_ACT * V_ACT;
   localparam logic [7:0]  THRESH     = 8'd128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/cam_capture_bw_if.sv
// Camera byte stream in, 1-bit frame-buffer write port out.
interface cam_capture_bw_if;
   import cam_pkg::*;

   logic          cam_vsync;
   logic          cam_href;
   logic          cam_pvalid;
   logic [7:0]    cam_d;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_data;

   // Camera / frame-buffer side
   modport master (
      output cam_vsync, cam_href, cam_pvalid, cam_d,
      input  wr_en, wr_addr, wr_data
   );

   // Capture block side
   modport slave (
      input  cam_vsync, cam_href, cam_pvalid, cam_d,
      output wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/cam_edge_det.sv
// Registers camera vsync/href and flags their transitions in the cycle
// the new level is first seen.
module cam_edge_det (
   input  logic dclk,
   input  logic clr_n,
   input  logic vsync,
   input  logic href,
   output logic vsync_rise_c,
   output logic vsync_fall_c,
   output logic href_fall_c
);

   logic vsync_q;
   logic href_q;

   // Previous-cycle copies of the sync levels
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         href_q  <= href;
      end
   end

   assign vsync_rise_c = vsync & ~vsync_q;
   assign vsync_fall_c = ~vsync & vsync_q;
   assign href_fall_c  = ~href & href_q;

endmodule

// File: rtl/cam_capture_bw.sv
// Captures luma from a YUV422 camera stream, thresholds it to 1 bit and
// writes it row-major into the display frame buffer.
module cam_capture_bw #(
   parameter int unsigned H_ACT  = cam_pkg::H_ACT,
   parameter int unsigned V_ACT  = cam_pkg::V_ACT,
   parameter int unsigned AW     = cam_pkg::AW,
   parameter logic [7:0]  THRESH = cam_pkg::THRESH
) (
   input  logic             dclk,
   input  logic             clr_n,
   input  logic             capture_en,
   cam_capture_bw_if.slave  bus,
   output logic             frame_done,
   output logic [7:0]       frame_cnt,
   output logic             line_err,
   output logic             busy
);
   import cam_pkg::*;

   localparam int unsigned FRAME_PIX = H_ACT * V_ACT;
   localparam int unsigned CW        = $clog2(H_ACT + 1);
   localparam int unsigned RW        = $clog2(V_ACT + 1);

   localparam logic [CW-1:0] COL_END   = CW'(H_ACT);
   localparam logic [RW-1:0] ROW_END   = RW'(V_ACT);
   localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACT - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_PIX - 1);

   state_t        state;
   state_t        state_next;
   logic [RW-1:0] row;
   logic [RW-1:0] row_next;
   logic [CW-1:0] col;
   logic [CW-1:0] col_next;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_next;
   logic          phase;
   logic          phase_next;
   logic          wr_en_next;
   logic          wr_data_next;
   logic [AW-1:0] wr_addr_next;
   logic          err_next;
   logic          y_byte;
   logic          vsync_rise_c;
   logic          vsync_fall_c;
   logic          href_fall_c;

   cam_edge_det u_edge (
      .dclk         (dclk),
      .clr_n        (clr_n),
      .vsync        (bus.cam_vsync),
      .href         (bus.cam_href),
      .vsync_rise_c (vsync_rise_c),
      .vsync_fall_c (vsync_fall_c),
      .href_fall_c  (href_fall_c)
   );

   // Phase 0 of an active line carries the luma byte
   assign y_byte = bus.cam_pvalid & bus.cam_href & ~phase;

   // FSM state register
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state, pixel/line bookkeeping and write request
   always_comb begin
      state_next   = state;
      row_next     = row;
      col_next     = col;
      addr_next    = addr;
      phase_next   = bus.cam_href ? (phase ^ bus.cam_pvalid) : 1'b0;
      wr_en_next   = 1'b0;
      wr_data_next = 1'b0;
      wr_addr_next = '0;
      err_next     = line_err;

      case (state)
         IDLE: begin
            if (capture_en) state_next = SYNC;
         end

         SYNC: begin
            if (!capture_en) begin
               state_next = IDLE;
            end else if (vsync_fall_c) begin
               row_next   = '0;
               col_next   = '0;
               addr_next  = '0;
               phase_next = 1'b0;
               state_next = ACTIVE;
            end
         end

         ACTIVE: begin
            if (y_byte && (row < ROW_END)) begin
               if (col < COL_END) begin
                  wr_en_next   = 1'b1;
                  wr_data_next = (bus.cam_d >= THRESH);
                  wr_addr_next = addr;
                  col_next     = col + CW'(1);
                  addr_next    = (addr == ADDR_LAST) ? addr : addr + AW'(1);
               end else begin
                  err_next = 1'b1;
               end
            end

            // Realign to the next row start so a bad line cannot skew later rows;
            // the last row is left alone to keep the address inside the frame
            if (href_fall_c && (row < ROW_END)) begin
               if (col != COL_END) err_next = 1'b1;
               if (row != ROW_LAST) addr_next = addr + AW'(COL_END - col);
               col_next = '0;
               row_next = row + RW'(1);
            end

            // Line end in the same cycle is already folded into row_next
            if (vsync_rise_c) begin
               state_next = DONE;
               if (row_next != ROW_END) err_next = 1'b1;
            end
         end

         DONE: begin
            state_next = capture_en ? SYNC : IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers and registered outputs
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         row         <= '0;
         col         <= '0;
         addr        <= '0;
         phase       <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_data <= 1'b0;
         bus.wr_addr <= '0;
         frame_done  <= 1'b0;
         frame_cnt   <= 8'd0;
         line_err    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         row         <= row_next;
         col         <= col_next;
         addr        <= addr_next;
         phase       <= phase_next;
         bus.wr_en   <= wr_en_next;
         bus.wr_data <= wr_data_next;
         bus.wr_addr <= wr_addr_next;
         frame_done  <= (state_next == DONE);
         if (state_next == DONE) frame_cnt <= frame_cnt + 8'd1;
         line_err    <= err_next;
         busy        <= (state_next == SYNC) || (state_next == ACTIVE);
      end
   end

endmodule

// File: tb/tb_cam_capture_bw.sv
// Bench for cam_capture_bw on a reduced 40x12 geometry with randomized
// pixel values and byte gaps, checked against a row/column reference model.
`timescale 1ns/1ps
module tb_cam_capture_bw;

   localparam int unsigned TB_H   = 40;
   localparam int unsigned TB_V   = 12;
   localparam int unsigned TB_PIX = TB_H * TB_V;
   localparam int unsigned AW     = 19;

   logic       dclk;
   logic       clr_n;
   logic       capture_en;
   logic       frame_done;
   logic [7:0] frame_cnt;
   logic       line_err;
   logic       busy;

   cam_capture_bw_if bus ();

   cam_capture_bw #(
      .H_ACT  (TB_H),
      .V_ACT  (TB_V),
      .AW     (AW),
      .THRESH (8'd128)
   ) dut (
      .dclk       (dclk),
      .clr_n      (clr_n),
      .capture_en (capture_en),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .line_err   (line_err),
      .busy       (busy)
   );

   int total = 0;
   int bad   = 0;

   int wr_seen = 0;
   int fd_seen = 0;
   int last_addr = -1;
   bit fb [TB_PIX];

   bit capturing;
   int exp_writes;
   int cnt_exp;
   bit err_exp;

   int cfg_nlines, cfg_short_row, cfg_short_len, cfg_long_row, cfg_long_len;
   int cfg_pat, cfg_gap, cfg_drop_row, cfg_rst_row;
   bit cfg_sim_end;

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // Observed frame buffer contents and pulse counts
   always @(negedge dclk) begin
      if (bus.wr_en === 1'b1) begin
         wr_seen++;
         last_addr = int'(bus.wr_addr);
         if (int'(bus.wr_addr) < int'(TB_PIX)) fb[int'(bus.wr_addr)] = bus.wr_data;
      end
      if (frame_done === 1'b1) fd_seen++;
   end

   task automatic cfg_default();
      cfg_nlines    = TB_V;
      cfg_short_row = -1;
      cfg_short_len = TB_H - 8;
      cfg_long_row  = -1;
      cfg_long_len  = TB_H + 10;
      cfg_pat       = 0;
      cfg_gap       = 0;
      cfg_drop_row  = -1;
      cfg_rst_row   = -1;
      cfg_sim_end   = 1'b0;
   endtask

   function automatic int len_of(input int r);
      int n;
      n = TB_H;
      if (r == cfg_short_row) n = cfg_short_len;
      if (r == cfg_long_row)  n = cfg_long_len;
      return n;
   endfunction

   function automatic logic [7:0] pix_of(input int r, input int c);
      logic [7:0] y;
      y = 8'($urandom);
      if (cfg_pat == 1) y = (c == 0) ? 8'd200 : 8'd50;
      if (cfg_pat == 2 && r == 0 && c == 0) y = 8'd127;
      if (cfg_pat == 2 && r == 0 && c == 1) y = 8'd128;
      return y;
   endfunction

   // One Y byte plus one chroma byte; the write must show one cycle after the Y strobe
   task automatic send_pix(input int r, input int c, input logic [7:0] y);
      bit   exp_wr;
      logic exp_d;
      exp_wr = capturing && (r < int'(TB_V)) && (c < int'(TB_H));
      exp_d  = (y >= 8'd128);
      if (exp_wr) exp_writes++;
      repeat ($urandom_range(0, cfg_gap)) @(negedge dclk);
      bus.cam_d      = y;
      bus.cam_pvalid = 1'b1;
      @(negedge dclk);
      bus.cam_pvalid = 1'b0;
      total++;
      if (bus.wr_en !== exp_wr) begin
         bad++;
         $display("FAIL wr_en r=%0d c=%0d got %b want %b", r, c, bus.wr_en, exp_wr);
      end else if (exp_wr) begin
         total++;
         if (bus.wr_addr !== AW'(r * int'(TB_H) + c) || bus.wr_data !== exp_d) begin
            bad++;
            $display("FAIL wr_addr/data r=%0d c=%0d y=%0d got %0d/%b want %0d/%b",
                     r, c, y, bus.wr_addr, bus.wr_data, r * int'(TB_H) + c, exp_d);
         end
      end
      repeat ($urandom_range(0, cfg_gap)) @(negedge dclk);
      bus.cam_d      = 8'($urandom);
      bus.cam_pvalid = 1'b1;
      @(negedge dclk);
      bus.cam_pvalid = 1'b0;
   endtask

   task automatic mid_reset();
      clr_n = 1'b0;
      #1;
      total++;
      if ({bus.wr_en, frame_done, frame_cnt, line_err, busy} !== 12'd0) begin
         bad++;
         $display("FAIL mid_reset outputs got wr_en=%b fd=%b cnt=%0d err=%b busy=%b want all 0",
                  bus.wr_en, frame_done, frame_cnt, line_err, busy);
      end
      @(negedge dclk);
      @(negedge dclk);
      clr_n     = 1'b1;
      capturing = 1'b0;
      cnt_exp   = 0;
      err_exp   = 1'b0;
   endtask

   // Frame start, cfg_nlines lines, frame end; then frame-level checks
   task automatic run_frame(input bit armed);
      int fd0, wr0;
      bit err_frame;
      capturing  = armed;
      exp_writes = 0;
      fd0 = fd_seen;
      wr0 = wr_seen;
      bus.cam_vsync = 1'b1;
      repeat (3) @(negedge dclk);
      bus.cam_vsync = 1'b0;
      repeat (2) @(negedge dclk);
      for (int r = 0; r < cfg_nlines; r++) begin
         if (r == cfg_drop_row) capture_en = 1'b0;
         if (r == cfg_rst_row) mid_reset();
         bus.cam_href = 1'b1;
         for (int c = 0; c < len_of(r); c++) send_pix(r, c, pix_of(r, c));
         bus.cam_href = 1'b0;
         if (r == cfg_nlines - 1 && cfg_sim_end) bus.cam_vsync = 1'b1;
         else repeat (2) @(negedge dclk);
      end
      bus.cam_vsync = 1'b1;
      repeat (5) @(negedge dclk);

      err_frame = (cfg_nlines < int'(TB_V));
      for (int r = 0; r < cfg_nlines && r < int'(TB_V); r++)
         if (len_of(r) != int'(TB_H)) err_frame = 1'b1;
      if (capturing) begin
         cnt_exp = (cnt_exp + 1) % 256;
         err_exp = err_exp | err_frame;
      end

      total++;
      if (wr_seen - wr0 !== exp_writes) begin
         bad++;
         $display("FAIL write_count got %0d want %0d", wr_seen - wr0, exp_writes);
      end
      total++;
      if (fd_seen - fd0 !== (capturing ? 1 : 0)) begin
         bad++;
         $display("FAIL frame_done_pulses got %0d want %0d", fd_seen - fd0, capturing ? 1 : 0);
      end
      total++;
      if (frame_cnt !== 8'(cnt_exp)) begin
         bad++;
         $display("FAIL frame_cnt got %0d want %0d", frame_cnt, cnt_exp);
      end
      total++;
      if (line_err !== err_exp) begin
         bad++;
         $display("FAIL line_err got %b want %b", line_err, err_exp);
      end
      total++;
      if (busy !== capture_en) begin
         bad++;
         $display("FAIL busy_after_frame got %b want %b", busy, capture_en);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         capture_en     = 1'($urandom);
         bus.cam_vsync  = 1'($urandom);
         bus.cam_href   = 1'($urandom);
         bus.cam_pvalid = 1'($urandom);
         bus.cam_d      = 8'($urandom);
         @(negedge dclk);
         total++;
         if ({bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, frame_cnt, line_err, busy} !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs i=%0d got wr_en=%b addr=%0d fd=%b cnt=%0d err=%b busy=%b want all 0",
                     i, bus.wr_en, bus.wr_addr, frame_done, frame_cnt, line_err, busy);
         end
      end
      capture_en     = 1'b1;
      bus.cam_vsync  = 1'b0;
      bus.cam_href   = 1'b0;
      bus.cam_pvalid = 1'b0;
      @(negedge dclk);
      clr_n = 1'b1;
      // Bytes without a frame start must not be written
      for (int i = 0; i < 60; i++) begin
         bus.cam_href   = (i % 20) < 16;
         bus.cam_pvalid = 1'($urandom);
         bus.cam_d      = 8'($urandom);
         @(negedge dclk);
      end
      bus.cam_href   = 1'b0;
      bus.cam_pvalid = 1'b0;
      @(negedge dclk);
      total++;
      if (wr_seen !== 0) begin
         bad++;
         $display("FAIL no_write_before_frame got %0d writes want 0", wr_seen);
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_in_sync got %b want 1", busy);
      end
      cnt_exp = 0;
      err_exp = 1'b0;
   endtask

   task automatic test_full_frame();
      int wr0;
      cfg_default();
      cfg_pat = 1;
      wr0 = wr_seen;
      run_frame(1'b1);
      total++;
      if (wr_seen - wr0 !== int'(TB_PIX)) begin
         bad++;
         $display("FAIL full_write_count got %0d want %0d", wr_seen - wr0, TB_PIX);
      end
      total++;
      if (fb[0] !== 1'b1 || fb[1] !== 1'b0) begin
         bad++;
         $display("FAIL full_first_pixels got %b%b want 10", fb[0], fb[1]);
      end
      total++;
      if (last_addr !== int'(TB_PIX) - 1) begin
         bad++;
         $display("FAIL full_last_addr got %0d want %0d", last_addr, TB_PIX - 1);
      end
   endtask

   task automatic test_threshold();
      cfg_default();
      cfg_pat = 2;
      cfg_gap = 2;
      run_frame(1'b1);
      total++;
      if (fb[0] !== 1'b0 || fb[1] !== 1'b1) begin
         bad++;
         $display("FAIL threshold_127_128 got %b/%b want 0/1", fb[0], fb[1]);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         cfg_default();
         cfg_gap     = 2;
         cfg_nlines  = int'(TB_V) + int'($urandom_range(0, 2));
         cfg_sim_end = 1'($urandom);
         run_frame(1'b1);
      end
   endtask

   task automatic test_long_line();
      cfg_default();
      cfg_long_row = 0;
      cfg_gap      = 1;
      run_frame(1'b1);
   endtask

   task automatic test_reset_mid();
      cfg_default();
      cfg_rst_row = 4;
      run_frame(1'b1);
   endtask

   task automatic test_short_line();
      cfg_default();
      cfg_short_row = 5;
      cfg_sim_end   = 1'b1;
      run_frame(1'b1);
   endtask

   task automatic test_few_lines();
      clr_n = 1'b0;
      @(negedge dclk);
      clr_n   = 1'b1;
      cnt_exp = 0;
      err_exp = 1'b0;
      cfg_default();
      cfg_nlines = int'(TB_V) - 3;
      run_frame(1'b1);
   endtask

   task automatic test_capture_drop();
      cfg_default();
      cfg_drop_row = int'(TB_V) / 2;
      run_frame(1'b1);
      cfg_default();
      run_frame(1'b0);
      capture_en = 1'b1;
      @(negedge dclk);
   endtask

   initial begin
      clr_n          = 1'b0;
      capture_en     = 1'b0;
      bus.cam_vsync  = 1'b0;
      bus.cam_href   = 1'b0;
      bus.cam_pvalid = 1'b0;
      bus.cam_d      = 8'd0;
      cfg_default();
      @(negedge dclk);
      test_reset();
      test_full_frame();
      test_threshold();
      test_random_frames();
      test_long_line();
      test_reset_mid();
      test_short_line();
      test_few_lines();
      test_capture_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
